// File: rtl/riscv_conv_tile_sched.sv
// riscv_conv_tile_sched
//   Run sequencer for the 3x3 Winograd engine. One run produces one 2x2
//   output tile: optionally fetch the N_W kernel weights, fetch the TILE x TILE
//   input tile (row-major, strided rows), pulse the engine start, wait for
//   done, then write the OUT x OUT results back (strided rows).
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start_i, cfg_*_i  : run request and run configuration (captured in IDLE)
//   busy_o, done_o    : run in progress / one-cycle completion pulse
//   data_*            : LSU-style req/gnt/rvalid port, one outstanding access
//   eng_wload_o/widx  : weight strobe/index toward the engine
//   eng_dvalid_o/didx : tile-word strobe/index toward the engine
//   eng_data_o        : registered read data for either strobe
//   eng_start_o       : one-cycle compute start
//   eng_done_i, eng_y_i : compute finished, {y3,y2,y1,y0}
//
// Optional feature: define RISCV_CONV_SCHED_RELU_EN to add relu_i. When the
//   captured relu_i is 1, every negative result is written back as 0.
module riscv_conv_tile_sched #(
  parameter int N_W  = 9,
  parameter int TILE = 4,
  parameter int OUT  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         cfg_wload_i,
  input  logic [31:0]  cfg_w_addr_i,
  input  logic [31:0]  cfg_in_addr_i,
  input  logic [31:0]  cfg_in_stride_i,
  input  logic [31:0]  cfg_out_addr_i,
  input  logic [31:0]  cfg_out_stride_i,
`ifdef RISCV_CONV_SCHED_RELU_EN
  input  logic         relu_i,
`endif
  output logic         busy_o,
  output logic         done_o,
  output logic         data_req_o,
  input  logic         data_gnt_i,
  input  logic         data_rvalid_i,
  output logic         data_we_o,
  output logic [31:0]  data_addr_o,
  output logic [31:0]  data_wdata_o,
  input  logic [31:0]  data_rdata_i,
  output logic         eng_wload_o,
  output logic [3:0]   eng_widx_o,
  output logic         eng_dvalid_o,
  output logic [3:0]   eng_didx_o,
  output logic [31:0]  eng_data_o,
  output logic         eng_start_o,
  input  logic         eng_done_i,
  input  logic [127:0] eng_y_i
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_REQ   = 4'd1;
  localparam logic [3:0] S_W_WAIT  = 4'd2;
  localparam logic [3:0] S_D_REQ   = 4'd3;
  localparam logic [3:0] S_D_WAIT  = 4'd4;
  localparam logic [3:0] S_START   = 4'd5;
  localparam logic [3:0] S_COMPUTE = 4'd6;
  localparam logic [3:0] S_WB_REQ  = 4'd7;
  localparam logic [3:0] S_WB_WAIT = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;

  localparam logic [3:0] W_LAST = 4'(N_W - 1);
  localparam logic [3:0] D_LAST = 4'(TILE * TILE - 1);
  localparam logic [3:0] O_LAST = 4'(OUT * OUT - 1);

  typedef struct packed {
    logic [31:0] w_addr;
    logic [31:0] in_addr;
    logic [31:0] in_stride;
    logic [31:0] out_addr;
    logic [31:0] out_stride;
    logic        relu;
  } cfg_t;

  logic [3:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;        // k, i or j depending on phase
  cfg_t         cfg_q, cfg_d;
  logic [127:0] y_q, y_d;
  logic         eng_wload_q, eng_wload_d;
  logic         eng_dvalid_q, eng_dvalid_d;
  logic [3:0]   eng_idx_q, eng_idx_d;
  logic [31:0]  eng_data_q, eng_data_d;

  logic         relu_in;
  logic [31:0]  cnt32, w_addr, t_addr, o_addr, y_sel, wb_data;

`ifdef RISCV_CONV_SCHED_RELU_EN
  assign relu_in = relu_i;
`else
  assign relu_in = 1'b0;
`endif

  // Address generation from the running index; all sums wrap mod 2^32.
  assign cnt32  = 32'(cnt_q);
  assign w_addr = cfg_q.w_addr + (cnt32 << 2);
  assign t_addr = cfg_q.in_addr + (cnt32 / 32'(TILE)) * cfg_q.in_stride
                + ((cnt32 % 32'(TILE)) << 2);
  assign o_addr = cfg_q.out_addr + (cnt32 / 32'(OUT)) * cfg_q.out_stride
                + ((cnt32 % 32'(OUT)) << 2);

  assign y_sel   = y_q[32*cnt_q[1:0] +: 32];
  assign wb_data = (cfg_q.relu && y_sel[31]) ? 32'd0 : y_sel;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cfg_d        = cfg_q;
    y_d          = y_q;
    eng_wload_d  = 1'b0;
    eng_dvalid_d = 1'b0;
    eng_idx_d    = eng_idx_q;
    eng_data_d   = eng_data_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        cfg_d   = '{cfg_w_addr_i, cfg_in_addr_i, cfg_in_stride_i,
                    cfg_out_addr_i, cfg_out_stride_i, relu_in};
        cnt_d   = '0;
        state_d = cfg_wload_i ? S_W_REQ : S_D_REQ;
      end
      S_W_REQ: if (data_gnt_i) state_d = S_W_WAIT;
      S_W_WAIT: if (data_rvalid_i) begin
        eng_wload_d = 1'b1;
        eng_idx_d   = cnt_q;
        eng_data_d  = data_rdata_i;
        if (cnt_q == W_LAST) begin
          cnt_d   = '0;
          state_d = S_D_REQ;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = S_W_REQ;
        end
      end
      S_D_REQ: if (data_gnt_i) state_d = S_D_WAIT;
      S_D_WAIT: if (data_rvalid_i) begin
        eng_dvalid_d = 1'b1;
        eng_idx_d    = cnt_q;
        eng_data_d   = data_rdata_i;
        if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = S_D_REQ;
        end
      end
      S_START: state_d = S_COMPUTE;
      S_COMPUTE: if (eng_done_i) begin
        y_d     = eng_y_i;
        cnt_d   = '0;
        state_d = S_WB_REQ;
      end
      S_WB_REQ: if (data_gnt_i) state_d = S_WB_WAIT;
      S_WB_WAIT: if (data_rvalid_i) begin
        if (cnt_q == O_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = S_WB_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cfg_q        <= '0;
      y_q          <= '0;
      eng_wload_q  <= 1'b0;
      eng_dvalid_q <= 1'b0;
      eng_idx_q    <= '0;
      eng_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_q        <= cfg_d;
      y_q          <= y_d;
      eng_wload_q  <= eng_wload_d;
      eng_dvalid_q <= eng_dvalid_d;
      eng_idx_q    <= eng_idx_d;
      eng_data_q   <= eng_data_d;
    end
  end

  // Request fields are pure functions of state/index/config, so they stay
  // stable for as long as the REQ state waits on gnt.
  always_comb begin
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    case (state_q)
      S_W_REQ:  begin data_req_o = 1'b1; data_addr_o = w_addr; end
      S_D_REQ:  begin data_req_o = 1'b1; data_addr_o = t_addr; end
      S_WB_REQ: begin
        data_req_o   = 1'b1;
        data_we_o    = 1'b1;
        data_addr_o  = o_addr;
        data_wdata_o = wb_data;
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign eng_start_o  = (state_q == S_START);
  assign eng_wload_o  = eng_wload_q;
  assign eng_dvalid_o = eng_dvalid_q;
  assign eng_widx_o   = eng_idx_q;
  assign eng_didx_o   = eng_idx_q;
  assign eng_data_o   = eng_data_q;

endmodule

// File: tb/tb_riscv_conv_tile_sched.sv
// Bench for riscv_conv_tile_sched: a stimulus process issues runs and queues
// the expected bus accesses, engine strobes and done timing; a memory model
// and an engine model answer the DUT; a monitor checks against the queues.
module tb_riscv_conv_tile_sched;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic         start_i = 0, cfg_wload_i = 0;
  logic [31:0]  cfg_w_addr_i = 0, cfg_in_addr_i = 0, cfg_in_stride_i = 0;
  logic [31:0]  cfg_out_addr_i = 0, cfg_out_stride_i = 0;
  logic         busy_o, done_o, data_req_o, data_we_o;
  logic         data_gnt_i = 0, data_rvalid_i = 0;
  logic [31:0]  data_addr_o, data_wdata_o, data_rdata_i = 0;
  logic         eng_wload_o, eng_dvalid_o, eng_start_o;
  logic [3:0]   eng_widx_o, eng_didx_o;
  logic [31:0]  eng_data_o;
  logic         eng_done_i = 0;
  logic [127:0] eng_y_i = 0;
`ifdef RISCV_CONV_SCHED_RELU_EN
  logic         relu_i = 0;
`endif

  riscv_conv_tile_sched dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_wload_i(cfg_wload_i),
    .cfg_w_addr_i(cfg_w_addr_i), .cfg_in_addr_i(cfg_in_addr_i),
    .cfg_in_stride_i(cfg_in_stride_i), .cfg_out_addr_i(cfg_out_addr_i),
    .cfg_out_stride_i(cfg_out_stride_i),
`ifdef RISCV_CONV_SCHED_RELU_EN
    .relu_i(relu_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_we_o(data_we_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .eng_wload_o(eng_wload_o), .eng_widx_o(eng_widx_o), .eng_dvalid_o(eng_dvalid_o),
    .eng_didx_o(eng_didx_o), .eng_data_o(eng_data_o), .eng_start_o(eng_start_o),
    .eng_done_i(eng_done_i), .eng_y_i(eng_y_i)
  );

  typedef struct { logic [31:0] a; logic we; logic [31:0] d; } bus_t;
  typedef struct { logic w; logic [3:0] idx; logic [31:0] d; } eng_t;
  bus_t exp_bus[$];
  eng_t exp_eng[$];
  int   exp_done[$];

  int total = 0, bad = 0, done_cnt = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Memory contents as a fixed function of the byte address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic any_out();
    return busy_o | done_o | data_req_o | data_we_o | (|data_addr_o) | (|data_wdata_o)
         | eng_wload_o | (|eng_widx_o) | eng_dvalid_o | (|eng_didx_o) | (|eng_data_o)
         | eng_start_o;
  endfunction

  // ---------------- memory responder ----------------
  bit          mode_rand = 0, spur_rv = 0, spur_done = 0, pend = 0;
  int          rdly = 0, hold_left = 0, eng_lat = 1, ecnt = 0;
  logic [31:0] hold_addr = 0, paddr = 0;
  logic        pwe = 0;

  always @(negedge clk) begin
    if (rst) begin
      pend = 0; data_gnt_i = 0; data_rvalid_i = 0;
    end else begin
      if (data_rvalid_i) pend = 0;
      data_rvalid_i = 0;
      if (data_gnt_i) begin
        pend = 1;
        rdly = mode_rand ? $urandom_range(0, 2) : 0;
      end
      data_gnt_i = 0;
      if (pend) begin
        if (rdly == 0) begin
          data_rvalid_i = 1;
          data_rdata_i  = pwe ? $urandom : memf(paddr);
        end else rdly--;
      end else if (spur_rv) begin
        data_rvalid_i = 1; data_rdata_i = $urandom; spur_rv = 0;
      end
      if (!pend && data_req_o) begin
        if (hold_left > 0 && data_addr_o == hold_addr) hold_left--;
        else if (mode_rand && $urandom_range(0, 2) == 0) ;
        else begin data_gnt_i = 1; paddr = data_addr_o; pwe = data_we_o; end
      end
    end
  end

  // ---------------- engine model ----------------
  always @(negedge clk) begin
    eng_done_i = 0;
    if (rst) ecnt = 0;
    else begin
      if (ecnt > 0) begin ecnt--; if (ecnt == 0) eng_done_i = 1; end
      if (eng_start_o) ecnt = eng_lat;
      if (spur_done) begin eng_done_i = 1; spur_done = 0; end
    end
  end

  // ---------------- monitor ----------------
  bit outst = 0, busy_chk = 0;
  always @(negedge clk) begin
    bus_t b; eng_t e; int x;
    #1;
    if (rst) begin outst = 0; busy_chk = 0; end
    else begin
      if (busy_chk) begin chk("busy_after_done", busy_o, 0); busy_chk = 0; end
      if (data_rvalid_i) outst = 0;
      if (data_req_o) begin
        chk("req_while_outstanding", outst, 0);
        chk("req_expected", exp_bus.size() != 0, 1);
        if (exp_bus.size() != 0) begin
          b = exp_bus[0];
          chk("bus_addr", data_addr_o, b.a);
          chk("bus_we", data_we_o, b.we);
          if (b.we) chk("bus_wdata", data_wdata_o, b.d);
          if (data_gnt_i) begin void'(exp_bus.pop_front()); outst = 1; end
        end
      end
      if (eng_wload_o || eng_dvalid_o) begin
        chk("eng_one_strobe", eng_wload_o & eng_dvalid_o, 0);
        chk("eng_expected", exp_eng.size() != 0, 1);
        if (exp_eng.size() != 0) begin
          e = exp_eng.pop_front();
          chk("eng_kind", eng_wload_o, e.w);
          chk("eng_idx", e.w ? eng_widx_o : eng_didx_o, e.idx);
          chk("eng_data", eng_data_o, e.d);
        end
      end
      if (done_o) begin
        chk("done_with_busy", busy_o, 1);
        chk("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) begin
          x = exp_done.pop_front();
          if (x >= 0) chk("latency_cycle", cyc, x);
          chk("queues_drained", exp_bus.size() + exp_eng.size(), 0);
        end
        done_cnt++;
        busy_chk = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit wl, input logic [31:0] wa, ia, is, oa, os,
                       input logic [127:0] y, input bit relu, input int lat);
    bus_t b; eng_t e;
    @(negedge clk);
    cfg_wload_i = wl; cfg_w_addr_i = wa; cfg_in_addr_i = ia; cfg_in_stride_i = is;
    cfg_out_addr_i = oa; cfg_out_stride_i = os; eng_y_i = y;
`ifdef RISCV_CONV_SCHED_RELU_EN
    relu_i = relu;
`endif
    start_i = 1;
    if (wl) for (int k = 0; k < 9; k++) begin
      b.a = wa + 32'(4 * k); b.we = 0; b.d = 0; exp_bus.push_back(b);
      e.w = 1; e.idx = 4'(k); e.d = memf(b.a); exp_eng.push_back(e);
    end
    for (int i = 0; i < 16; i++) begin
      b.a = ia + 32'(i / 4) * is + 32'(4 * (i % 4)); b.we = 0; b.d = 0; exp_bus.push_back(b);
      e.w = 0; e.idx = 4'(i); e.d = memf(b.a); exp_eng.push_back(e);
    end
    for (int j = 0; j < 4; j++) begin
      b.a = oa + 32'(j / 2) * os + 32'(4 * (j % 2)); b.we = 1; b.d = y[32*j +: 32];
`ifdef RISCV_CONV_SCHED_RELU_EN
      if (relu && b.d[31]) b.d = 0;
`endif
      exp_bus.push_back(b);
    end
    exp_done.push_back(lat < 0 ? -1 : cyc + lat);
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 4000) begin @(negedge clk); #2; n++; end
    chk("done_count", done_cnt, target);
  endtask

  function automatic logic [127:0] rnd_y();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int n; bit found;
    repeat (3) @(negedge clk);
    #2 chk("reset_outputs_zero", any_out(), 0);
    @(negedge clk); rst = 0;

    // Directed zero-wait runs with exact latency.
    issue(1, 32'h100, 32'h200, 16, 32'h300, 8, rnd_y(), 0, 61);
    wait_done(1);
    issue(0, 32'h100, 32'h200, 64, 32'h400, 8, rnd_y(), 0, 43);
    wait_done(2);

    // gnt withheld three cycles on tile word 5 (0x200 + 16 + 4).
    hold_addr = 32'h214; hold_left = 3;
    issue(0, 32'h0, 32'h200, 16, 32'h500, 8, rnd_y(), 0, 46);
    wait_done(3);
    chk("hold_consumed", hold_left, 0);

    // start_i during COMPUTE is ignored.
    eng_lat = 6;
    issue(1, 32'h600, 32'h700, 32, 32'h800, 16, rnd_y(), 0, 66);
    n = 0;
    while (!eng_start_o && n < 500) begin @(negedge clk); #1; n++; end
    chk("saw_eng_start", eng_start_o, 1);
    @(negedge clk); start_i = 1;
    @(negedge clk); start_i = 0;
    wait_done(4);
    eng_lat = 1;
    repeat (10) @(negedge clk);
    #2 chk("no_rerun_busy", busy_o, 0);
    chk("no_rerun_done_count", done_cnt, 4);

    // Spurious rvalid / eng_done in IDLE.
    spur_rv = 1; spur_done = 1;
    repeat (6) begin @(negedge clk); #2 chk("idle_stays_idle", busy_o, 0); end

    // Reset pulse while waiting for tile word 3 (0x900 + 12).
    issue(1, 32'hA00, 32'h900, 16, 32'hB00, 8, rnd_y(), 0, -1);
    n = 0; found = 0;
    while (!found && n < 500) begin
      @(negedge clk); #1;
      if (data_req_o && data_gnt_i && data_addr_o == 32'h90C) found = 1;
      n++;
    end
    chk("reached_tile3_grant", found, 1);
    @(negedge clk); #2 rst = 1;
    @(negedge clk); #2 rst = 0;
    exp_bus.delete(); exp_eng.delete(); exp_done.delete();
    chk("mid_reset_outputs_zero", any_out(), 0);
    chk("mid_reset_busy", busy_o, 0);
    repeat (3) @(negedge clk);
    issue(1, 32'h100, 32'h200, 16, 32'h300, 8, rnd_y(), 0, 61);
    wait_done(5);

    // Results {5,-3,0,-1}; with the relu build these write as 0,0,0,5.
    issue(1, 32'h40, 32'h80, 16, 32'hC0, 8,
          {32'd5, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFF}, 1, 61);
    wait_done(6);

    // Randomized runs with random gnt/rvalid/engine delays.
    mode_rand = 1;
    for (int r = 0; r < 6; r++) begin
      eng_lat = $urandom_range(1, 4);
      issue($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom, $urandom,
            rnd_y(), $urandom_range(0, 1), -1);
      wait_done(7 + r);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
